// File: rtl/mcu_link_sequencer_pkg.sv
// Shared types and constants for the MCU-side link sequencer.
// The TX and RX state encodings are kept here so that the top level and any future probes use one definition.
package mcu_link_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        T_IDLE,
        T_SETUP,
        T_PULSE,
        T_ARM,
        T_WAIT
    } tx_state_t;

    typedef enum logic [2:0] {
        R_INIT,
        R_WAIT,
        R_SAMPLE,
        R_HOLD,
        R_ACK,
        R_CLEAR
    } rx_state_t;

endpackage

// File: rtl/mcu_link_sequencer_flag_sync.sv
// Multi-flop synchronizer for a single asynchronous CPLD flag.
// The reset value is a parameter so that each flag can power up in its inactive level.
module flag_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_link_sequencer.sv
// MCU-side sequencer for the 6502 interface CPLD: buffered TX handshake and RX capture.
// TX and RX run as independent FSMs; all CPLD-facing strobes are registered.
module mcu_link_sequencer
    import mcu_link_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 4,
    parameter int SAMPLE_CYC  = 2
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [BYTE_W-1:0]           S_TX_DATA,
    input  logic                        S_TX_VALID,
    output logic                        S_TX_READY,
    output logic [BYTE_W-1:0]           M_RX_DATA,
    output logic                        M_RX_VALID,
    input  logic                        M_RX_READY,
    output logic [BYTE_W-1:0]           TX_DATA,
    output logic                        TX_LOAD,
    input  logic [BYTE_W-1:0]           RX_DATA,
    output logic                        RX_OE_N,
    output logic                        RX_ACK,
    input  logic                        DATA_TAKEN,
    input  logic                        DATA_WRITTEN,
    output logic [$clog2(FIFO_DEPTH):0] TX_LEVEL,
    output logic                        LINK_IDLE
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic dt_s;
    logic dw_s;

    // DATA_TAKEN idles high (latch empty), DATA_WRITTEN idles low.
    flag_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_sync_taken (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (DATA_TAKEN),
        .q     (dt_s)
    );

    flag_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sync_written (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (DATA_WRITTEN),
        .q     (dw_s)
    );

    tx_state_t        tx_state, tx_next;
    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] tx_cnt, rx_cnt;

    logic [BYTE_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;
    logic              rdy_en;
    logic              push, pop;
    logic              fifo_empty, fifo_full;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign pop        = (tx_state == T_IDLE) && !fifo_empty;
    // A full FIFO still accepts a byte in the cycle the head is popped.
    assign S_TX_READY = rdy_en && (!fifo_full || pop);
    assign push       = S_TX_VALID && S_TX_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdy_en <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= S_TX_DATA;
    end

    assign TX_LEVEL  = level;
    assign LINK_IDLE = fifo_empty && (tx_state == T_IDLE);

    logic tx_load_nxt, rx_ack_nxt, rx_oe_n_nxt, m_valid_nxt, rx_capture;

    // State registers, phase counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_state   <= T_IDLE;
            rx_state   <= R_INIT;
            tx_cnt     <= '0;
            rx_cnt     <= '0;
            TX_LOAD    <= 1'b0;
            RX_ACK     <= 1'b0;
            RX_OE_N    <= 1'b1;
            M_RX_VALID <= 1'b0;
            TX_DATA    <= '0;
            M_RX_DATA  <= '0;
        end else begin
            tx_state   <= tx_next;
            rx_state   <= rx_next;
            tx_cnt     <= (tx_next != tx_state) ? '0 : tx_cnt + CNT_W'(1);
            rx_cnt     <= (rx_next != rx_state) ? '0 : rx_cnt + CNT_W'(1);
            TX_LOAD    <= tx_load_nxt;
            RX_ACK     <= rx_ack_nxt;
            RX_OE_N    <= rx_oe_n_nxt;
            M_RX_VALID <= m_valid_nxt;
            if (pop)        TX_DATA   <= fifo_mem[rd_ptr];
            if (rx_capture) M_RX_DATA <= RX_DATA;
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:  if (!fifo_empty)                        tx_next = T_SETUP;
            T_SETUP: if (tx_cnt == CNT_W'(SETUP_CYC - 1))    tx_next = T_PULSE;
            T_PULSE: if (tx_cnt == CNT_W'(PULSE_CYC - 1))    tx_next = T_ARM;
            T_ARM:   if (!dt_s)                              tx_next = T_WAIT;
            T_WAIT:  if (dt_s)                               tx_next = T_IDLE;
            default:                                         tx_next = T_IDLE;
        endcase
    end

    // R_INIT is entered from reset with RX_ACK still low, so it runs one extra count.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_INIT:   if (rx_cnt == CNT_W'(PULSE_CYC))       rx_next = R_WAIT;
            R_WAIT:   if (dw_s)                              rx_next = R_SAMPLE;
            R_SAMPLE: if (rx_cnt == CNT_W'(SAMPLE_CYC - 1))  rx_next = R_HOLD;
            R_HOLD:   if (M_RX_READY)                        rx_next = R_ACK;
            R_ACK:    if (rx_cnt == CNT_W'(PULSE_CYC - 1))   rx_next = R_CLEAR;
            R_CLEAR:  if (!dw_s)                             rx_next = R_WAIT;
            default:                                         rx_next = R_WAIT;
        endcase
    end

    // Strobes are decoded from the next state and registered, so they never glitch.
    always_comb begin
        tx_load_nxt = (tx_next == T_PULSE);
        rx_ack_nxt  = (rx_next == R_INIT) || (rx_next == R_ACK);
        rx_oe_n_nxt = (rx_next != R_SAMPLE);
        m_valid_nxt = (rx_next == R_HOLD);
        rx_capture  = (rx_state == R_SAMPLE) && (rx_next == R_HOLD);
    end

endmodule

// File: tb/tb_mcu_link_sequencer.sv
// Directed bench for mcu_link_sequencer with a behavioural CPLD on the TX side.
module tb_mcu_link_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] S_TX_DATA;
    logic       S_TX_VALID;
    logic       S_TX_READY;
    logic [7:0] M_RX_DATA;
    logic       M_RX_VALID;
    logic       M_RX_READY;
    logic [7:0] TX_DATA;
    logic       TX_LOAD;
    logic [7:0] RX_DATA;
    logic       RX_OE_N;
    logic       RX_ACK;
    logic       DATA_TAKEN;
    logic       DATA_WRITTEN;
    logic [2:0] TX_LEVEL;
    logic       LINK_IDLE;

    mcu_link_sequencer dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .S_TX_DATA    (S_TX_DATA),
        .S_TX_VALID   (S_TX_VALID),
        .S_TX_READY   (S_TX_READY),
        .M_RX_DATA    (M_RX_DATA),
        .M_RX_VALID   (M_RX_VALID),
        .M_RX_READY   (M_RX_READY),
        .TX_DATA      (TX_DATA),
        .TX_LOAD      (TX_LOAD),
        .RX_DATA      (RX_DATA),
        .RX_OE_N      (RX_OE_N),
        .RX_ACK       (RX_ACK),
        .DATA_TAKEN   (DATA_TAKEN),
        .DATA_WRITTEN (DATA_WRITTEN),
        .TX_LEVEL     (TX_LEVEL),
        .LINK_IDLE    (LINK_IDLE)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Strobe-width counters sampled on the falling edge.
    int load_cnt = 0;
    int ack_cnt  = 0;
    int oe_cnt   = 0;
    always @(negedge CLK) begin
        if (TX_LOAD)  load_cnt <= load_cnt + 1;
        if (RX_ACK)   ack_cnt  <= ack_cnt + 1;
        if (!RX_OE_N) oe_cnt   <= oe_cnt + 1;
    end

    // CPLD/CPU model on the TX side: latch on TX_LOAD, drop DATA_TAKEN 3 clocks later, CPU reads 20 clocks after that.
    logic [7:0] latched[$];
    logic       cpu_stall = 1'b0;
    initial begin
        DATA_TAKEN = 1'b1;
        forever begin
            @(posedge TX_LOAD);
            latched.push_back(TX_DATA);
            repeat (3) @(posedge CLK);
            #2 DATA_TAKEN = 1'b0;
            while (cpu_stall) @(posedge CLK);
            repeat (20) @(posedge CLK);
            #2 DATA_TAKEN = 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_init_pulse(input string name);
        logic [5:0] pat;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            pat = {pat[4:0], RX_ACK};
        end
        check(name, 32'(pat), 32'h3C);
    endtask

    // One RX byte from the CPU: raise DATA_WRITTEN, consume after 'hold' stalled cycles, clear on RX_ACK.
    task automatic rx_xfer(input logic [7:0] d, input int hold);
        int t_oe, t_ack, vcnt, guard;
        t_oe  = oe_cnt;
        t_ack = ack_cnt;
        RX_DATA      = d;
        DATA_WRITTEN = 1'b1;
        guard = 0;
        while (!M_RX_VALID && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        check("rx_valid_seen", 32'(M_RX_VALID), 32'd1);
        check("rx_oe_width", 32'(oe_cnt - t_oe), 32'd2);
        check("rx_data", 32'(M_RX_DATA), 32'(d));
        RX_DATA = ~d;
        vcnt = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            if (M_RX_VALID) vcnt++;
        end
        check("rx_valid_held", 32'(vcnt), 32'(hold));
        check("rx_data_held", 32'(M_RX_DATA), 32'(d));
        check("rx_ack_before_hs", 32'(ack_cnt - t_ack), 32'd0);
        M_RX_READY = 1'b1;
        @(negedge CLK);
        M_RX_READY = 1'b0;
        check("rx_valid_cleared", 32'(M_RX_VALID), 32'd0);
        check("rx_ack_after_hs", 32'(RX_ACK), 32'd1);
        repeat (6) @(negedge CLK);
        DATA_WRITTEN = 1'b0;
        repeat (5) @(negedge CLK);
        check("rx_ack_width", 32'(ack_cnt - t_ack), 32'd4);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic [2:0] lvl;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int base, l0, guard, w, lat;
        logic [7:0] prev1, prev2;
        logic idle_seen;

        tbl[0] = '{1'b1, 8'h01, 1'b1, 3'd1};
        tbl[1] = '{1'b1, 8'h02, 1'b1, 3'd1};
        tbl[2] = '{1'b1, 8'h03, 1'b1, 3'd2};
        tbl[3] = '{1'b1, 8'h04, 1'b1, 3'd3};
        tbl[4] = '{1'b1, 8'h05, 1'b1, 3'd4};
        tbl[5] = '{1'b1, 8'h06, 1'b0, 3'd4};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 3'd4};

        RST_N        = 1'b0;
        S_TX_DATA    = '0;
        S_TX_VALID   = 1'b0;
        M_RX_READY   = 1'b0;
        RX_DATA      = '0;
        DATA_WRITTEN = 1'b0;

        // Reset values and the R_INIT acknowledge pulse.
        repeat (3) @(negedge CLK);
        check("rst_ready", 32'(S_TX_READY), 32'd0);
        check("rst_tx_load", 32'(TX_LOAD), 32'd0);
        check("rst_rx_ack", 32'(RX_ACK), 32'd0);
        check("rst_oe_n", 32'(RX_OE_N), 32'd1);
        check("rst_rx_valid", 32'(M_RX_VALID), 32'd0);
        check("rst_level", 32'(TX_LEVEL), 32'd0);
        check("rst_link_idle", 32'(LINK_IDLE), 32'd1);
        check("rst_tx_data", 32'(TX_DATA), 32'd0);
        RST_N = 1'b1;
        check_init_pulse("init_ack_pulse");
        check("init_tx_load", 32'(load_cnt), 32'd0);
        check("init_oe_n", 32'(RX_OE_N), 32'd1);
        check("init_ready", 32'(S_TX_READY), 32'd1);
        check("init_link_idle", 32'(LINK_IDLE), 32'd1);

        // Single byte 0xA5 through the full TX handshake.
        base = latched.size();
        l0   = load_cnt;
        S_TX_DATA  = 8'hA5;
        S_TX_VALID = 1'b1;
        @(negedge CLK);
        S_TX_VALID = 1'b0;
        prev1 = TX_DATA;
        prev2 = 8'h00;
        guard = 0;
        while (!TX_LOAD && guard < 20) begin
            prev2 = prev1;
            prev1 = TX_DATA;
            @(negedge CLK);
            guard++;
        end
        check("a5_load_seen", 32'(TX_LOAD), 32'd1);
        check("a5_setup_2clk", 32'(prev2), 32'hA5);
        check("a5_setup_1clk", 32'(prev1), 32'hA5);
        w = 0;
        while (TX_LOAD && w < 20) begin
            w++;
            @(negedge CLK);
        end
        check("a5_load_width", 32'(w), 32'd4);
        guard = 0;
        while (DATA_TAKEN && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        idle_seen = 1'b0;
        guard = 0;
        while (!DATA_TAKEN && guard < 100) begin
            if (LINK_IDLE) idle_seen = 1'b1;
            check("a5_tx_data_hold", 32'(TX_DATA), 32'hA5);
            @(negedge CLK);
            guard++;
        end
        check("a5_idle_early", 32'(idle_seen), 32'd0);
        lat = 0;
        while (!LINK_IDLE && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check("a5_idle_latency", 32'(lat), 32'd3);
        check("a5_latched", 32'(latched[base]), 32'hA5);
        check("a5_load_total", 32'(load_cnt - l0), 32'd4);

        // Back-to-back pushes with the CPU stalled: FIFO fill and ready drop.
        base = latched.size();
        cpu_stall = 1'b1;
        for (int i = 0; i < 7; i++) begin
            S_TX_VALID = tbl[i].v;
            S_TX_DATA  = tbl[i].d;
            #1;
            check($sformatf("tbl%0d_ready", i), 32'(S_TX_READY), 32'(tbl[i].rdy));
            @(negedge CLK);
            check($sformatf("tbl%0d_level", i), 32'(TX_LEVEL), 32'(tbl[i].lvl));
        end
        S_TX_VALID = 1'b0;
        cpu_stall  = 1'b0;
        guard = 0;
        while (!((latched.size() - base == 5) && LINK_IDLE) && guard < 3000) begin
            @(negedge CLK);
            guard++;
        end
        check("order_count", 32'(latched.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < latched.size())
                check($sformatf("order_%0d", i), 32'(latched[base + i]), 32'(i + 1));
            else
                check($sformatf("order_%0d", i), 32'hFFFF_FFFF, 32'(i + 1));
        end

        // RX byte with a 10-cycle downstream stall.
        rx_xfer(8'h3C, 10);

        // TX 0x11 and RX 0x22 started in the same cycle.
        base = latched.size();
        l0   = load_cnt;
        S_TX_DATA  = 8'h11;
        S_TX_VALID = 1'b1;
        fork
            begin
                @(negedge CLK);
                S_TX_VALID = 1'b0;
                guard = 0;
                while (!((latched.size() > base) && LINK_IDLE) && guard < 300) begin
                    @(negedge CLK);
                    guard++;
                end
            end
            rx_xfer(8'h22, 0);
        join
        check("sim_tx_count", 32'(latched.size() - base), 32'd1);
        if (latched.size() > base)
            check("sim_tx_byte", 32'(latched[base]), 32'h11);
        else
            check("sim_tx_byte", 32'hFFFF_FFFF, 32'h11);
        check("sim_load_width", 32'(load_cnt - l0), 32'd4);

        // Reset asserted while TX_LOAD is high.
        repeat (30) @(negedge CLK);
        S_TX_VALID = 1'b1;
        S_TX_DATA  = 8'h77;
        @(negedge CLK);
        S_TX_DATA  = 8'h78;
        @(negedge CLK);
        S_TX_DATA  = 8'h79;
        @(negedge CLK);
        S_TX_VALID = 1'b0;
        guard = 0;
        while (!TX_LOAD && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        check("rstp_load_seen", 32'(TX_LOAD), 32'd1);
        check("rstp_level_before", 32'(TX_LEVEL), 32'd2);
        RST_N = 1'b0;
        #1;
        check("rstp_load_drop", 32'(TX_LOAD), 32'd0);
        check("rstp_level", 32'(TX_LEVEL), 32'd0);
        check("rstp_link_idle", 32'(LINK_IDLE), 32'd1);
        check("rstp_ready", 32'(S_TX_READY), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        check_init_pulse("rstp_init_pulse");
        repeat (40) @(negedge CLK);
        check("rstp_final_idle", 32'(LINK_IDLE), 32'd1);
        check("rstp_final_load", 32'(TX_LOAD), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
